// File: rtl/exhaustive_stim_seq_if.sv
// Bus between the test controller, the sweep sequencer and the swept datapath.
// The signature signal exists only when MISR_EN is defined.
interface exhaustive_stim_seq_if #(
   parameter int N_IN  = 6,
   parameter int OUT_W = 3
);
   logic             start;
   logic             abort;
   logic [OUT_W-1:0] dut_out;
   logic [N_IN-1:0]  stim;
   logic             stim_valid;
   logic             busy;
   logic             capt_valid;
   logic [OUT_W-1:0] capt_data;
   logic [N_IN-1:0]  capt_idx;
   logic             done;
`ifdef MISR_EN
   logic [15:0]      signature;
`endif

   // master = sequencer, slave = controller plus swept datapath
   modport master (
      input  start, abort, dut_out,
      output stim, stim_valid, busy, capt_valid, capt_data, capt_idx, done
`ifdef MISR_EN
      , output signature
`endif
   );

   modport slave (
      output start, abort, dut_out,
      input  stim, stim_valid, busy, capt_valid, capt_data, capt_idx, done
`ifdef MISR_EN
      , input signature
`endif
   );
endinterface

// File: rtl/exhaustive_stim_seq.sv
// Sweeps all 2**N_IN input vectors, holding each DWELL cycles and capturing dut_out
// on the last one. Define MISR_EN to add a 16-bit MISR signature over the captures.
module exhaustive_stim_seq #(
   parameter int N_IN  = 6,
   parameter int OUT_W = 3,
   parameter int DWELL = 10
) (
   input logic                   clk,
   input logic                   rst,
   exhaustive_stim_seq_if.master bus
);
   localparam int               CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);
   localparam logic [N_IN-1:0]  LAST_VEC   = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N_IN-1:0]  stim_q;
   logic [N_IN-1:0]  capt_idx_q;
   logic [OUT_W-1:0] capt_data_q;
   logic             stim_valid_q;
   logic             busy_q;
   logic             capt_valid_q;
   logic             done_q;

   logic start_ok;
   logic capture_edge;

   // abort has priority over both a new start and a pending capture
   assign start_ok     = (state_q == IDLE) && bus.start && !bus.abort;
   assign capture_edge = (state_q == APPLY) && !bus.abort && (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         stim_q       <= '0;
         capt_idx_q   <= '0;
         capt_data_q  <= '0;
         stim_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         capt_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         capt_valid_q <= 1'b0;
         done_q       <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_ok) begin
                  state_q      <= APPLY;
                  stim_q       <= '0;
                  cnt_q        <= CNT_RELOAD;
                  stim_valid_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            APPLY: begin
               if (bus.abort) begin
                  state_q      <= IDLE;
                  stim_q       <= '0;
                  cnt_q        <= '0;
                  stim_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
               end else if (capture_edge) begin
                  capt_valid_q <= 1'b1;
                  capt_data_q  <= bus.dut_out;
                  capt_idx_q   <= stim_q;
                  // terminal vector leaves the sweep instead of wrapping
                  if (stim_q == LAST_VEC) begin
                     state_q      <= DONE;
                     done_q       <= 1'b1;
                     stim_q       <= '0;
                     stim_valid_q <= 1'b0;
                     busy_q       <= 1'b0;
                  end else begin
                     stim_q <= stim_q + 1'b1;
                     cnt_q  <= CNT_RELOAD;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.stim       = stim_q;
   assign bus.stim_valid = stim_valid_q;
   assign bus.busy       = busy_q;
   assign bus.capt_valid = capt_valid_q;
   assign bus.capt_data  = capt_data_q;
   assign bus.capt_idx   = capt_idx_q;
   assign bus.done       = done_q;

`ifdef MISR_EN
   logic [15:0] sig_q;
   logic [15:0] sig_d;
   logic [15:0] dut_ext;

   always_comb begin
      dut_ext              = '0;
      dut_ext[OUT_W-1:0]   = bus.dut_out;
      sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]} ^ dut_ext;
   end

   // signature persists after DONE or abort until the next accepted start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
      end else if (start_ok) begin
         sig_q <= '0;
      end else if (capture_edge) begin
         sig_q <= sig_d;
      end
   end

   assign bus.signature = sig_q;
`endif
endmodule
